// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding word reads to instruction
// memory and queues the returned words, tagged with their addresses, in a
// small FIFO for the consumer. A redirect flushes the FIFO and restarts
// fetching; a read still in flight at the redirect is tracked and its data
// dropped.
//
// Ports:
//   CLk, reset                      clock, synchronous active-high reset
//   mem_req, mem_address            read request pulse and word address
//   mem_ready, mem_instruction      read response pulse and data
//   inst_valid, instruction,        registered FIFO head: valid flag, word
//   inst_pc                         and its word address
//   inst_ready                      consumer accepts the head
//   redirect, redirect_pc           flush and restart at redirect_pc
//   buf_count                       occupied FIFO entries
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     CLk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [31:0]              mem_address,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_instruction,
  output logic                     inst_valid,
  output logic [31:0]              instruction,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Read-tracking states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   ipc_q, ipc_d;

  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          push_c;
  logic          pop_c;
  logic          flush_c;
  logic          may_issue_c;
  logic          issue_c;
  logic [CW-1:0] occ_c;

  // Next-state, FIFO bookkeeping and request generation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    push_c      = 1'b0;
    flush_c     = 1'b0;
    may_issue_c = 1'b0;
    pop_c       = valid_q && inst_ready && !redirect;

    case (state_q)
      S_IDLE: begin
        // mem_ready is meaningless here: nothing is outstanding
        if (redirect) begin
          flush_c = 1'b1;
          pc_d    = redirect_pc;
        end else begin
          may_issue_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          flush_c = 1'b1;
          pc_d    = redirect_pc;
          state_d = mem_ready ? S_IDLE : S_DISCARD;
        end else if (mem_ready) begin
          push_c      = 1'b1;
          pc_d        = pc_q + 32'd1;
          state_d     = S_IDLE;
          may_issue_c = 1'b1;
        end
      end
      S_DISCARD: begin
        // Stale response: drop it, and do not issue in the same cycle
        if (redirect) begin
          flush_c = 1'b1;
          pc_d    = redirect_pc;
          if (mem_ready) state_d = S_IDLE;
        end else if (mem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue only if the eventual response is guaranteed a free entry
    occ_c   = count_q + CW'(push_c) - CW'(pop_c);
    issue_c = may_issue_c && !reset && (occ_c < CW'(DEPTH));
    if (issue_c) state_d = S_WAIT;

    if (flush_c) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = occ_c;
      rd_ptr_d = rd_ptr_q + PW'(pop_c);
      wr_ptr_d = wr_ptr_q + PW'(push_c);
    end
    valid_d = (count_d != '0);

    // Next head: bypass the incoming word when it lands at the head slot
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (count_d != '0) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
        instr_d = mem_instruction;
        ipc_d   = pc_q;
      end else begin
        instr_d = mem_instr_q[rd_ptr_d];
        ipc_d   = mem_pc_q[rd_ptr_d];
      end
    end

    mem_req     = issue_c;
    mem_address = issue_c ? pc_d : 32'h0;
  end

  // Control and head registers
  always_ff @(posedge CLk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      ipc_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge CLk) begin
    if (push_c && !reset) begin
      mem_instr_q[wr_ptr_q] <= mem_instruction;
      mem_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign inst_pc     = ipc_q;
  assign buf_count   = count_q;

endmodule
